// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline hazard controller signal bundle
// master: pipeline side, drives stage info and reads controls
// slave : controller side, reads stage info and drives controls
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic id_use_src1;
  logic id_use_src2;
  logic [3:0] ex_dest;
  logic ex_wb_en;
  logic ex_mem_r_en;
  logic [3:0] mem_dest;
  logic mem_wb_en;
  logic mem_req;
  logic b_taken;
  logic cnt_clr;
  logic pc_freeze;
  logic if_id_freeze;
  logic if_id_flush;
  logic id_ex_flush;
  logic pipe_freeze;
  logic mem_ready;
  logic sram_busy;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_src1, id_src2, id_use_src1, id_use_src2, ex_dest, ex_wb_en, ex_mem_r_en,
           mem_dest, mem_wb_en, mem_req, b_taken, cnt_clr,
    input  pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_ready,
           sram_busy, stall_cnt
  );
  modport slave (
    input  id_src1, id_src2, id_use_src1, id_use_src2, ex_dest, ex_wb_en, ex_mem_r_en,
           mem_dest, mem_wb_en, mem_req, b_taken, cnt_clr,
    output pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_ready,
           sram_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush sequencing for RAW hazards, taken branches and SRAM wait states
// Ports: clk, rst (async, active-high), bus (pipe_hazard_ctrl_if.slave) carrying ID/EX/MEM
// stage info, mem_req, b_taken, cnt_clr in and the freeze/flush controls, mem_ready,
// sram_busy and the saturating stall_cnt out.
// Macro FWD_HAZARD_EN: forwarding present, only load-use hazards stall.
module pipe_hazard_ctrl #(
  parameter int MEM_WAIT = 3,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic hz, mem_stall;
`ifdef FWD_HAZARD_EN
  logic unused_mem;
  assign unused_mem = bus.mem_wb_en ^ (^bus.mem_dest);
  assign hz = bus.ex_mem_r_en & bus.ex_wb_en &
              ((bus.id_use_src1 & (bus.ex_dest == bus.id_src1)) |
               (bus.id_use_src2 & (bus.ex_dest == bus.id_src2)));
`else
  logic unused_ld, m1, m2;
  assign unused_ld = bus.ex_mem_r_en;
  assign m1 = (bus.ex_wb_en & (bus.ex_dest == bus.id_src1)) | (bus.mem_wb_en & (bus.mem_dest == bus.id_src1));
  assign m2 = (bus.ex_wb_en & (bus.ex_dest == bus.id_src2)) | (bus.mem_wb_en & (bus.mem_dest == bus.id_src2));
  assign hz = (bus.id_use_src1 & m1) | (bus.id_use_src2 & m2);
`endif
  // rst gating keeps every control low while reset is held, even with mem_req high in IDLE
  assign mem_stall = ~rst & (((state == IDLE) & bus.mem_req) | (state == ACCESS));
  // a branch squashes the hazarding instruction, so hz only stalls when no branch is taken
  assign bus.pc_freeze = ~rst & (mem_stall | (~bus.b_taken & hz));
  assign bus.if_id_freeze = bus.pc_freeze;
  assign bus.if_id_flush = ~rst & ~mem_stall & bus.b_taken;
  assign bus.id_ex_flush = ~rst & ~mem_stall & (bus.b_taken | hz);
  assign bus.pipe_freeze = mem_stall;
  assign bus.mem_ready = ~rst & (state == DONE);
  assign bus.sram_busy = ~rst & (state != IDLE);
  assign bus.stall_cnt = cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (bus.mem_req) begin
          state <= (MEM_WAIT == 1) ? DONE : ACCESS;
          wcnt <= 4'(MEM_WAIT - 1);
        end
        ACCESS: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) state <= DONE;
        end
        default: state <= IDLE;
      endcase
      cnt <= bus.cnt_clr ? '0 : (bus.pc_freeze & ~&cnt) ? cnt + 1'b1 : cnt;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl (MEM_WAIT=3, CNT_W=16)
module tb_pipe_hazard_ctrl;
  logic clk, rst;
  pipe_hazard_ctrl_if #(.CNT_W(16)) bus();
  pipe_hazard_ctrl #(.MEM_WAIT(3), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b1;
  always #5 clk = ~clk;
  // control vector: {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_ready, sram_busy}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] STL0 = 7'b1100100;
  localparam logic [6:0] STLA = 7'b1100101;
  localparam logic [6:0] DONE = 7'b0000011;
  localparam logic [6:0] DNBR = 7'b0011011;
  localparam logic [6:0] HZ   = 7'b1101000;
  localparam logic [6:0] BR   = 7'b0011000;
`ifdef FWD_HAZARD_EN
  localparam logic [6:0] HZNF = NONE;
`else
  localparam logic [6:0] HZNF = HZ;
`endif
  typedef struct {string nm; logic [6:0] ctl; logic [15:0] cnt;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_cnt = 16'd0;
  always @(negedge clk) if (q.size() != 0) begin
    exp_t x;
    logic [6:0] act;
    x = q.pop_front();
    act = {bus.pc_freeze, bus.if_id_freeze, bus.if_id_flush, bus.id_ex_flush,
           bus.pipe_freeze, bus.mem_ready, bus.sram_busy};
    n_chk++;
    if (act !== x.ctl) begin
      n_fail++;
      $display("FAIL %s ctl: got %b expected %b", x.nm, act, x.ctl);
    end
    n_chk++;
    if (bus.stall_cnt !== x.cnt) begin
      n_fail++;
      $display("FAIL %s stall_cnt: got %h expected %h", x.nm, bus.stall_cnt, x.cnt);
    end
  end
  task automatic cyc(input string nm, input logic [6:0] e);
    q.push_back('{nm, e, rst ? 16'd0 : exp_cnt});
    @(posedge clk); #1;
    if (rst || bus.cnt_clr) exp_cnt = 16'd0;
    else if (e[6] && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask
  task automatic clr_in();
    bus.id_src1 = 0; bus.id_src2 = 0; bus.id_use_src1 = 0; bus.id_use_src2 = 0;
    bus.ex_dest = 0; bus.ex_wb_en = 0; bus.ex_mem_r_en = 0; bus.mem_dest = 0;
    bus.mem_wb_en = 0; bus.mem_req = 0; bus.b_taken = 0; bus.cnt_clr = 0;
  endtask
  initial begin
    clr_in();
    rst = 1; bus.mem_req = 1;
    cyc("reset_held", NONE);
    rst = 0;
    cyc("mem_idle_req", STL0);
    cyc("mem_acc1", STLA);
    cyc("mem_acc2", STLA);
    cyc("mem_done_req_ignored", DONE);
    bus.mem_req = 0;
    cyc("idle_after_mem", NONE);
    bus.ex_wb_en = 1; bus.ex_dest = 4; bus.id_src1 = 4; bus.id_use_src1 = 1;
    cyc("ex_hz_src1", HZNF);
    bus.ex_mem_r_en = 1;
    cyc("load_use_src1", HZ);
    bus.ex_wb_en = 0; bus.ex_mem_r_en = 0; bus.mem_wb_en = 1; bus.mem_dest = 4;
    cyc("mem_hz_src1", HZNF);
    bus.id_src1 = 1; bus.id_src2 = 4; bus.id_use_src2 = 0;
    cyc("src2_not_used", NONE);
    bus.id_use_src2 = 1;
    cyc("mem_hz_src2", HZNF);
    bus.mem_wb_en = 0;
    cyc("no_wb_no_hz", NONE);
    bus.ex_wb_en = 1; bus.ex_mem_r_en = 1; bus.ex_dest = 4; bus.b_taken = 1;
    cyc("hz_plus_branch", BR);
    clr_in();
    bus.b_taken = 1; bus.mem_req = 1;
    cyc("br_mem_idle", STL0);
    bus.mem_req = 0;
    cyc("br_mem_acc1", STLA);
    cyc("br_mem_acc2", STLA);
    cyc("br_mem_done_flush", DNBR);
    bus.b_taken = 0;
    cyc("after_br_mem", NONE);
    bus.mem_req = 1;
    cyc("rst_mem_idle", STL0);
    cyc("rst_mem_acc1", STLA);
    rst = 1;
    cyc("rst_in_acc2", NONE);
    rst = 0;
    cyc("restart_idle", STL0);
    bus.mem_req = 0;
    cyc("restart_acc1", STLA);
    cyc("restart_acc2", STLA);
    cyc("restart_done", DONE);
    cyc("restart_idle_end", NONE);
    bus.cnt_clr = 1;
    cyc("cnt_clr_idle", NONE);
    bus.cnt_clr = 0;
    bus.ex_wb_en = 1; bus.ex_mem_r_en = 1; bus.ex_dest = 7; bus.id_src1 = 7; bus.id_use_src1 = 1;
    repeat (65534) begin
      @(posedge clk); #1;
      exp_cnt++;
    end
    cyc("sat_fffe", HZ);
    cyc("sat_ffff", HZ);
    cyc("sat_hold", HZ);
    bus.cnt_clr = 1;
    cyc("clr_in_stall", HZ);
    bus.cnt_clr = 0;
    cyc("after_clr", HZ);
    clr_in();
    cyc("final_idle", NONE);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage ARM core. It drives the freeze/flush controls of the PC, the IF/ID register and the ID/EX register (ID_Stage_Reg.flush), plus the freezes of the EX/MEM and MEM/WB registers. It resolves three events: RAW data hazards, taken branches, and multi-cycle SRAM accesses in MEM, the last via a wait-state FSM. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
MEM_WAIT, 3, number of stall cycles per MEM-stage SRAM access; legal range 1..15.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
id_src1  input  4  Rn index of the instruction in ID
id_src2  input  4  Rm/Rd-store index of the instruction in ID
id_use_src1  input  1  ID instruction reads src1
id_use_src2  input  1  ID instruction reads src2
ex_dest  input  4  destination of the instruction in EX
ex_wb_en  input  1  EX instruction writes back
ex_mem_r_en  input  1  EX instruction is a load
mem_dest  input  4  destination of the instruction in MEM
mem_wb_en  input  1  MEM instruction writes back
mem_req  input  1  MEM instruction reads or writes SRAM
b_taken  input  1  taken branch resolved in EX
cnt_clr  input  1  synchronous clear of stall_cnt
pc_freeze  output  1  hold the PC
if_id_freeze  output  1  hold the IF/ID register
if_id_flush  output  1  clear the IF/ID register
id_ex_flush  output  1  load a bubble into ID/EX
pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB
mem_ready  output  1  SRAM access completes this cycle
sram_busy  output  1  memory FSM not IDLE
stall_cnt  output  CNT_W  cycles with any stall, saturating

Behaviour:
- Memory FSM states: IDLE, ACCESS, DONE; 4-bit wait counter wcnt.
- IDLE, mem_req=1:
  - If MEM_WAIT=1, go to DONE; otherwise load wcnt=MEM_WAIT-1 and go to ACCESS.
- IDLE, mem_req=0: stay in IDLE.
- ACCESS: wcnt decrements each cycle; on the cycle with wcnt=1, go to DONE.
- DONE: mem_ready=1 for exactly one cycle, then IDLE unconditionally. mem_req is ignored in DONE.
- mem_stall = (IDLE & mem_req) | ACCESS. An access therefore stalls exactly MEM_WAIT cycles, followed by one non-stall DONE cycle.
- sram_busy = (state != IDLE).
- Data hazard (no forwarding):
  - hz = (id_use_src1 & match(id_src1)) | (id_use_src2 & match(id_src2)).
  - match(r) = (ex_wb_en & ex_dest==r) | (mem_wb_en & mem_dest==r).
- Priority, evaluated combinationally every cycle:
  1. mem_stall: pc_freeze=if_id_freeze=pipe_freeze=1; all flushes 0.
  2. b_taken: if_id_flush=1, id_ex_flush=1; no freeze. A coincident hz is ignored, because the hazarding instruction is flushed.
  3. hz: pc_freeze=1, if_id_freeze=1, id_ex_flush=1 (bubble).
  4. Otherwise all controls 0.
- Simultaneous mem_stall and b_taken: the stall wins; the branch flush is applied on the first non-stall cycle, since b_taken is held by the frozen EX stage.
- stall_cnt: increments on each clock where pc_freeze=1, saturating at all-ones.
  - cnt_clr has priority over the increment and sets stall_cnt to 0.
- Reset, async:
  - state=IDLE, wcnt=0, stall_cnt=0.
  - While rst=1, every control output and mem_ready/sram_busy is forced to 0.
  - Reset during ACCESS aborts the access; after rst falls, a still-asserted mem_req starts a full new MEM_WAIT-cycle stall.
- All outputs other than stall_cnt are combinational from state and inputs. stall_cnt is registered.

Optional Feature:
Macro FWD_HAZARD_EN.
- Defined: a forwarding unit exists, so only load-use hazards stall.
  - hz = ex_mem_r_en & ex_wb_en & ((id_use_src1 & ex_dest==id_src1) | (id_use_src2 & ex_dest==id_src2)).
  - MEM-stage matches never stall.
- Undefined: the full EX+MEM match rule above applies.

Test Plan:
- Reset with mem_req=1 held, release rst -> pc_freeze=pipe_freeze=1 for exactly 3 cycles (MEM_WAIT=3), mem_ready=1 on the 4th cycle, stall_cnt=3.
- ex_wb_en=1, ex_dest=4, id_src1=4, id_use_src1=1, no FWD_HAZARD_EN -> pc_freeze=if_id_freeze=id_ex_flush=1. With FWD_HAZARD_EN and ex_mem_r_en=0 -> all controls 0.
- Same hazard plus b_taken=1 -> if_id_flush=id_ex_flush=1, pc_freeze=0.
- mem_req=1 and b_taken=1 together -> 3 freeze cycles with flushes 0, then if_id_flush=id_ex_flush=1 on the DONE cycle.
- Assert rst in the second ACCESS cycle -> outputs 0 immediately; after release with mem_req=1 -> a new 3-cycle stall.
- Preload stall_cnt to 0xFFFE via a long stall -> saturates at 0xFFFF; cnt_clr=1 during a stall -> stall_cnt=0 next cycle.
